// File: rtl/tlk2711_pkg.sv
// -----------------------------------------------------------------------------
// tlk2711_pkg
// Shared definitions for the TLK2711 DMA read-command arbiter:
//   - arb_state_e  : arbiter FSM state encoding
//   - CH_TX/CH_AUX : requester channel indices
//   - CMD_ADDR_LSB / cmd_len_lsb() : command word field offsets
//   - rr_select()  : round-robin channel pick for a two-requester arbiter
// -----------------------------------------------------------------------------
package tlk2711_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACKW  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_BUSY  = 2'd3
  } arb_state_e;

  localparam logic CH_TX  = 1'b0;  // TX command path
  localparam logic CH_AUX = 1'b1;  // auxiliary / replay path

  // Command word = {len, addr}: address sits at the bottom, length above it.
  localparam int CMD_ADDR_LSB = 0;

  function automatic int cmd_len_lsb(input int addr_width);
    return CMD_ADDR_LSB + addr_width;
  endfunction

  // rr names the channel that has priority (the one not served last).
  // It wins whenever it is requesting; otherwise the other channel is taken.
  function automatic logic rr_select(input logic [1:0] req, input logic rr);
    logic sel;
    if (req[rr]) begin
      sel = rr;
    end else begin
      sel = ~rr;
    end
    return sel;
  endfunction

endpackage

// File: rtl/tlk2711_dma_cmd_arb.sv
// -----------------------------------------------------------------------------
// tlk2711_dma_cmd_arb
// Two-requester round-robin arbiter in front of the DMA read-command port.
// A winning command word is latched, acknowledged to its requester for one
// cycle, issued downstream until accepted, and the channel then owns the read
// stream until its last beat.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_soft_rst          : synchronous abort / clear of FSM, errors, counters
//   i_req[1:0]          : level requests (ch0 = TX, ch1 = aux/replay)
//   i_cmd_data0/1       : requester command words {len, addr}
//   o_ack[1:0]          : one-cycle acknowledge to the selected requester
//   o_rd_cmd_req/data   : read command toward the DMA
//   i_rd_cmd_ack        : DMA accepted the command
//   i_dma_rd_valid/ready/last : observed read stream handshake
//   o_owner, o_owner_vld: channel owning the read stream
//   o_zero_len_err      : sticky, a zero-length command was latched
//   o_timeout_err       : sticky, the DMA never accepted a command in time
//   o_grant_cnt0/1      : completed-command counters (wrap at 16 bits)
// -----------------------------------------------------------------------------
module tlk2711_dma_cmd_arb
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH  = 48,
  parameter int DLEN_WIDTH  = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_soft_rst,
  input  logic [1:0]                     i_req,
  input  logic [DLEN_WIDTH+ADDR_WIDTH-1:0] i_cmd_data0,
  input  logic [DLEN_WIDTH+ADDR_WIDTH-1:0] i_cmd_data1,
  output logic [1:0]                     o_ack,
  output logic                           o_rd_cmd_req,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
  input  logic                           i_rd_cmd_ack,
  input  logic                           i_dma_rd_valid,
  input  logic                           i_dma_rd_ready,
  input  logic                           i_dma_rd_last,
  output logic                           o_owner,
  output logic                           o_owner_vld,
  output logic                           o_zero_len_err,
  output logic                           o_timeout_err,
  output logic [15:0]                    o_grant_cnt0,
  output logic [15:0]                    o_grant_cnt1
);

  localparam int CMD_WIDTH = DLEN_WIDTH + ADDR_WIDTH;
  localparam int LEN_LSB   = cmd_len_lsb(ADDR_WIDTH);
  // Counter only needs to reach ACK_TIMEOUT-1: the last ISSUE cycle.
  localparam int TO_WIDTH  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(ACK_TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  sel_q, sel_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic [1:0]            ack_q, ack_d;
  logic                  rd_req_q, rd_req_d;
  logic                  owner_vld_q, owner_vld_d;
  logic                  zero_err_q, zero_err_d;
  logic                  to_err_q, to_err_d;
  logic [15:0]           grant_cnt0_q, grant_cnt0_d;
  logic [15:0]           grant_cnt1_q, grant_cnt1_d;

  logic                  sel_s;
  logic [CMD_WIDTH-1:0]  req_cmd_s;
  logic                  len_zero_s;
  logic                  last_beat_s;
  logic                  to_hit_s;

  assign sel_s       = rr_select(i_req, rr_q);
  assign req_cmd_s   = (sel_s == CH_AUX) ? i_cmd_data1 : i_cmd_data0;
  assign len_zero_s  = (cmd_q[LEN_LSB +: DLEN_WIDTH] == {DLEN_WIDTH{1'b0}});
  assign last_beat_s = i_dma_rd_valid & i_dma_rd_ready & i_dma_rd_last;
  assign to_hit_s    = (to_cnt_q == TO_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (i_soft_rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|i_req) begin
            state_d = ST_ACKW;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACKW: begin
          // Zero-length commands are acknowledged but never issued.
          if (len_zero_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // An ack on the final allowed cycle still counts as accepted.
          if (i_rd_cmd_ack) begin
            state_d = ST_BUSY;
          end else if (to_hit_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_BUSY: begin
          if (last_beat_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM output / datapath logic: next values of all registered outputs.
  always_comb begin
    rr_d         = rr_q;
    sel_d        = sel_q;
    cmd_d        = cmd_q;
    to_cnt_d     = to_cnt_q;
    ack_d        = 2'b00;
    rd_req_d     = 1'b0;
    owner_vld_d  = 1'b0;
    zero_err_d   = zero_err_q;
    to_err_d     = to_err_q;
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (i_soft_rst) begin
      rr_d         = CH_TX;
      sel_d        = CH_TX;
      cmd_d        = {CMD_WIDTH{1'b0}};
      to_cnt_d     = {TO_WIDTH{1'b0}};
      zero_err_d   = 1'b0;
      to_err_d     = 1'b0;
      grant_cnt0_d = 16'd0;
      grant_cnt1_d = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|i_req) begin
            sel_d = sel_s;
            cmd_d = req_cmd_s;
            ack_d = (sel_s == CH_AUX) ? 2'b10 : 2'b01;
          end else begin
            sel_d = sel_q;
          end
        end
        ST_ACKW: begin
          if (len_zero_s) begin
            zero_err_d = 1'b1;
            rr_d       = ~sel_q;
          end else begin
            rd_req_d = 1'b1;
            to_cnt_d = {TO_WIDTH{1'b0}};
          end
        end
        ST_ISSUE: begin
          if (i_rd_cmd_ack) begin
            owner_vld_d = 1'b1;
          end else if (to_hit_s) begin
            to_err_d = 1'b1;
          end else begin
            rd_req_d = 1'b1;
            to_cnt_d = to_cnt_q + TO_WIDTH'(1'b1);
          end
        end
        ST_BUSY: begin
          if (last_beat_s) begin
            rr_d = ~sel_q;
            if (sel_q == CH_TX) begin
              grant_cnt0_d = grant_cnt0_q + 16'd1;
            end else begin
              grant_cnt1_d = grant_cnt1_q + 16'd1;
            end
          end else begin
            owner_vld_d = 1'b1;
          end
        end
        default: begin
          rr_d = rr_q;
        end
      endcase
    end
  end

  // Datapath and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= CH_TX;
      sel_q        <= CH_TX;
      cmd_q        <= {CMD_WIDTH{1'b0}};
      to_cnt_q     <= {TO_WIDTH{1'b0}};
      ack_q        <= 2'b00;
      rd_req_q     <= 1'b0;
      owner_vld_q  <= 1'b0;
      zero_err_q   <= 1'b0;
      to_err_q     <= 1'b0;
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
    end else begin
      rr_q         <= rr_d;
      sel_q        <= sel_d;
      cmd_q        <= cmd_d;
      to_cnt_q     <= to_cnt_d;
      ack_q        <= ack_d;
      rd_req_q     <= rd_req_d;
      owner_vld_q  <= owner_vld_d;
      zero_err_q   <= zero_err_d;
      to_err_q     <= to_err_d;
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign o_ack          = ack_q;
  assign o_rd_cmd_req   = rd_req_q;
  assign o_rd_cmd_data  = cmd_q;
  assign o_owner        = sel_q;
  assign o_owner_vld    = owner_vld_q;
  assign o_zero_len_err = zero_err_q;
  assign o_timeout_err  = to_err_q;
  assign o_grant_cnt0   = grant_cnt0_q;
  assign o_grant_cnt1   = grant_cnt1_q;

endmodule
